// File: rtl/a25_wishbone_pkg.sv
// Shared definitions for the A25 wishbone memory responder.
// Holds the responder state encoding, bus width constants and the
// read pattern returned for accesses that fall outside the memory window.
package a25_wishbone_pkg;

    localparam int DATA_W = 128;
    localparam int BE_W   = 16;
    localparam int ADDR_W = 32;

    // Returned in place of SRAM data for out-of-window reads.
    localparam logic [DATA_W-1:0] ERR_RDATA = {4{32'hDEADBEEF}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RWAIT = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

endpackage

// File: rtl/a25_wishbone_resp.sv
// Purpose: single-port responder turning port-buffer requests into synchronous SRAM accesses.
// Latency: writes complete in the accept cycle; read data is valid 2+READ_WAIT cycles after accept.
// Backpressure: o_accepted is low while a read is outstanding; the master holds its request.
//
// Ports: i_clk / i_rst_n (async active-low); request side i_valid, i_write, i_wdata, i_be,
// i_addr -> o_accepted; response side o_rdata, o_rdata_valid, o_err; SRAM side o_mem_en,
// o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata.
// Optional feature: define A25_WISHBONE_RESP_ERR_EN to check i_addr against the MEM_BASE
// window and flag out-of-window accesses on o_err. Without it the window aliases.
module a25_wishbone_resp
    import a25_wishbone_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter int          READ_WAIT = 0,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_accepted,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_err,
    output logic              o_mem_en,
    output logic [BE_W-1:0]   o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_err_q;
    logic              in_win;
    logic              accept;
    logic              issue;

`ifdef A25_WISHBONE_RESP_ERR_EN
    assign in_win = (i_addr[ADDR_W-1:MEM_AW+4] == MEM_BASE[ADDR_W-1:MEM_AW+4]);
    // Byte offset within a word never matters.
    logic unused_addr_lo;
    assign unused_addr_lo = ^i_addr[3:0];
`else
    assign in_win = 1'b1;
    // Upper address bits are dropped on purpose so the window aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+4], i_addr[3:0], MEM_BASE};
`endif

    // Acceptance is gated by reset so nothing leaks out while i_rst_n is low.
    assign accept = i_rst_n && (state_q == ST_IDLE) && i_valid;
    assign issue  = accept && in_win;

    assign o_accepted  = accept;
    assign o_mem_en    = issue;
    assign o_mem_we    = (issue && i_write) ? i_be : '0;
    assign o_mem_addr  = issue ? i_addr[MEM_AW+3:4] : '0;
    assign o_mem_wdata = (issue && i_write) ? i_wdata : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && !i_write) state_d = ST_RWAIT;
            ST_RWAIT: if (wait_cnt_q == WAIT_LAST) state_d = ST_RDATA;
            ST_RDATA: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter only runs while staying in RWAIT; it is zero on RWAIT entry.
            if (state_q == ST_RWAIT && state_d == ST_RWAIT) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (accept && !i_write) begin
                rd_err_q <= !in_win;
            end
            // SRAM data is valid in the first RWAIT cycle; capture it there.
            if (state_q == ST_RWAIT && wait_cnt_q == 4'd0) begin
                rdata_q <= rd_err_q ? ERR_RDATA : i_mem_rdata;
            end
        end
    end

    assign o_rdata       = rdata_q;
    assign o_rdata_valid = (state_q == ST_RDATA);

`ifdef A25_WISHBONE_RESP_ERR_EN
    logic wr_err_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= accept && i_write && !in_win;
        end
    end
    assign o_err = wr_err_q || (o_rdata_valid && rd_err_q);
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_a25_wishbone_resp.sv
// Self-checking bench for a25_wishbone_resp: two instances (READ_WAIT 0 and 3)
// share request inputs; i_valid is steered to the selected one. Each has a
// behavioural SRAM; expected read data comes from a byte-merge reference memory.
module tb_a25_wishbone_resp;

    logic         clk, rst_n, vld, wr;
    int           sel;
    logic [127:0] wdata;
    logic [15:0]  be;
    logic [31:0]  addr;

    logic         acc0, rv0, err0, men0, acc3, rv3, err3, men3;
    logic [127:0] rdata0, mwd0, mrd0, rdata3, mwd3, mrd3;
    logic [15:0]  mwe0, mwe3;
    logic [9:0]   maddr0, maddr3;

    logic [127:0] sram0 [1024];
    logic [127:0] sram3 [1024];
    logic [127:0] ref_mem [2][1024];

    int checks = 0;
    int errors = 0;
    logic [127:0] last_rd;

    a25_wishbone_resp #(.MEM_AW(10), .READ_WAIT(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld && sel == 0), .i_write(wr),
        .i_wdata(wdata), .i_be(be), .i_addr(addr), .o_accepted(acc0),
        .o_rdata(rdata0), .o_rdata_valid(rv0), .o_err(err0), .o_mem_en(men0),
        .o_mem_we(mwe0), .o_mem_addr(maddr0), .o_mem_wdata(mwd0), .i_mem_rdata(mrd0));

    a25_wishbone_resp #(.MEM_AW(10), .READ_WAIT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld && sel == 1), .i_write(wr),
        .i_wdata(wdata), .i_be(be), .i_addr(addr), .o_accepted(acc3),
        .o_rdata(rdata3), .o_rdata_valid(rv3), .o_err(err3), .o_mem_en(men3),
        .o_mem_we(mwe3), .o_mem_addr(maddr3), .o_mem_wdata(mwd3), .i_mem_rdata(mrd3));

    // Outputs of the currently selected instance.
    logic         c_acc, c_rv, c_err, c_men;
    logic [127:0] c_rdata, c_mwd;
    logic [15:0]  c_mwe;
    logic [9:0]   c_maddr;
    assign c_acc   = sel == 1 ? acc3   : acc0;
    assign c_rv    = sel == 1 ? rv3    : rv0;
    assign c_err   = sel == 1 ? err3   : err0;
    assign c_men   = sel == 1 ? men3   : men0;
    assign c_rdata = sel == 1 ? rdata3 : rdata0;
    assign c_mwd   = sel == 1 ? mwd3   : mwd0;
    assign c_mwe   = sel == 1 ? mwe3   : mwe0;
    assign c_maddr = sel == 1 ? maddr3 : maddr0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (men0) begin
            for (int b = 0; b < 16; b++) if (mwe0[b]) sram0[maddr0][b*8 +: 8] <= mwd0[b*8 +: 8];
            mrd0 <= sram0[maddr0];
        end
        if (men3) begin
            for (int b = 0; b < 16; b++) if (mwe3[b]) sram3[maddr3][b*8 +: 8] <= mwd3[b*8 +: 8];
            mrd3 <= sram3[maddr3];
        end
    end

    task automatic do_write(input int s, input logic [31:0] a, input logic [127:0] d, input logic [15:0] b);
        @(negedge clk);
        sel = s; vld = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        #1;
        checks++; if (c_acc !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", c_acc); end
        checks++; if (c_men !== 1'b1) begin errors++; $display("FAIL wr_mem_en got %b want 1", c_men); end
        checks++; if (c_mwe !== b) begin errors++; $display("FAIL wr_mem_we got %h want %h", c_mwe, b); end
        checks++; if (c_maddr !== a[13:4]) begin errors++; $display("FAIL wr_mem_addr got %h want %h", c_maddr, a[13:4]); end
        checks++; if (c_mwd !== d) begin errors++; $display("FAIL wr_mem_wdata got %h want %h", c_mwd, d); end
        checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", c_err); end
        for (int i = 0; i < 16; i++) if (b[i]) ref_mem[s][a[13:4]][i*8 +: 8] = d[i*8 +: 8];
    endtask

    task automatic do_idle();
        @(negedge clk);
        vld = 1'b0; wr = 1'b0; be = '0;
        #1;
        checks++; if ({c_men, c_mwe, c_maddr, c_mwd} !== '0) begin errors++; $display("FAIL idle_mem_outputs got en=%b we=%h addr=%h wd=%h want all 0", c_men, c_mwe, c_maddr, c_mwd); end
    endtask

    // Read at cycle T; if hold, i_valid stays high through the wait cycles.
    task automatic do_read(input int s, input logic [31:0] a, input bit hold);
        int rw;
        logic [127:0] exp;
        rw = (s == 1) ? 3 : 0;
        @(negedge clk);
        sel = s; vld = 1'b1; wr = 1'b0; addr = a;
        be = 16'($urandom); wdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++; if (c_acc !== 1'b1) begin errors++; $display("FAIL rd_accept got %b want 1", c_acc); end
        checks++; if (c_men !== 1'b1 || c_mwe !== 16'h0 || c_mwd !== '0) begin errors++; $display("FAIL rd_mem_ctl got en=%b we=%h wd=%h want en=1 we=0 wd=0", c_men, c_mwe, c_mwd); end
        checks++; if (c_maddr !== a[13:4]) begin errors++; $display("FAIL rd_mem_addr got %h want %h", c_maddr, a[13:4]); end
        exp = ref_mem[s][a[13:4]];
        for (int k = 1; k <= rw + 2; k++) begin
            @(negedge clk);
            vld = hold;
            #1;
            checks++; if (c_acc !== 1'b0 || c_men !== 1'b0) begin errors++; $display("FAIL rd_busy T+%0d got acc=%b en=%b want 0 0", k, c_acc, c_men); end
            checks++; if (c_rv !== (k == rw + 2)) begin errors++; $display("FAIL rd_valid T+%0d got %b want %b", k, c_rv, k == rw + 2); end
            if (k == rw + 2) begin
                last_rd = c_rdata;
                checks++; if (c_rdata !== exp) begin errors++; $display("FAIL rd_data got %h want %h", c_rdata, exp); end
                checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", c_err); end
            end
        end
        vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld = 1'b1; wr = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++; if (c_acc !== 1'b0 || c_men !== 1'b0) begin errors++; $display("FAIL reset_acc_en dut%0d got acc=%b en=%b want 0 0", s, c_acc, c_men); end
            checks++; if (c_rdata !== '0 || c_rv !== 1'b0 || c_err !== 1'b0) begin errors++; $display("FAIL reset_outputs dut%0d got rdata=%h rv=%b err=%b want 0", s, c_rdata, c_rv, c_err); end
        end
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        do_write(0, 32'h40, d, 16'hFFFF);
        do_idle();
        do_read(0, 32'h40, 1'b0);
        checks++; if (last_rd !== d) begin errors++; $display("FAIL wr_rd_data got %h want %h", last_rd, d); end
        repeat (3) do_idle();
        checks++; if (rdata0 !== d) begin errors++; $display("FAIL rdata_hold got %h want %h", rdata0, d); end
    endtask

    task automatic test_partial();
        do_write(0, 32'h80, {4{32'hFFFF_FFFF}}, 16'hFFFF);
        do_write(0, 32'h80, 128'h1122_3344, 16'h000F);
        do_write(0, 32'h80, {4{$urandom}}, 16'h0000);
        do_idle();
        do_read(0, 32'h80, 1'b0);
        checks++; if (last_rd !== {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h1122_3344}) begin errors++; $display("FAIL partial_be got %h want ff..ff11223344", last_rd); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_write(1, 32'(32'h100 + i * 16), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
        do_idle();
        for (int i = 0; i < 4; i++) do_read(1, 32'(32'h100 + i * 16), 1'b0);
    endtask

    task automatic test_read_wait();
        do_write(1, 32'h200, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        do_idle();
        // Held request is ignored during the read, then accepted at T+6.
        do_read(1, 32'h200, 1'b1);
        do_read(1, 32'h200, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        sel = 1; vld = 1'b1; wr = 1'b0; addr = 32'h200;
        #1;
        checks++; if (c_acc !== 1'b1) begin errors++; $display("FAIL rst_mid_accept got %b want 1", c_acc); end
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (c_rv !== 1'b0 || c_acc !== 1'b0 || c_rdata !== '0) begin errors++; $display("FAIL rst_mid_quiet cyc%0d got rv=%b acc=%b rdata=%h want 0", k, c_rv, c_acc, c_rdata); end
            @(negedge clk);
        end
        vld = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (c_rv !== 1'b0) begin errors++; $display("FAIL rst_after_valid cyc%0d got %b want 0", k, c_rv); end
            @(negedge clk);
        end
        do_read(1, 32'h200, 1'b0);
    endtask

`ifdef A25_WISHBONE_RESP_ERR_EN
    task automatic test_window();
        @(negedge clk);
        sel = 0; vld = 1'b1; wr = 1'b1; addr = 32'h0001_0000; be = 16'hFFFF; wdata = '1;
        #1;
        checks++; if (c_acc !== 1'b1 || c_men !== 1'b0) begin errors++; $display("FAIL oow_wr got acc=%b en=%b want 1 0", c_acc, c_men); end
        @(negedge clk);
        vld = 1'b0;
        #1;
        checks++; if (c_err !== 1'b1) begin errors++; $display("FAIL oow_wr_err got %b want 1", c_err); end
        @(negedge clk);
        vld = 1'b1; wr = 1'b0; addr = 32'h0001_0000;
        #1;
        checks++; if (c_err !== 1'b0 || c_acc !== 1'b1 || c_men !== 1'b0) begin errors++; $display("FAIL oow_rd_accept got err=%b acc=%b en=%b want 0 1 0", c_err, c_acc, c_men); end
        @(negedge clk);
        vld = 1'b0;
        #1;
        checks++; if (c_rv !== 1'b0 || c_men !== 1'b0) begin errors++; $display("FAIL oow_rd_t1 got rv=%b en=%b want 0 0", c_rv, c_men); end
        @(negedge clk);
        #1;
        checks++; if (c_rv !== 1'b1 || c_err !== 1'b1) begin errors++; $display("FAIL oow_rd_pulse got rv=%b err=%b want 1 1", c_rv, c_err); end
        checks++; if (c_rdata !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL oow_rd_data got %h want deadbeef x4", c_rdata); end
        do_read(0, 32'h80, 1'b0);
    endtask
`else
    task automatic test_window();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        do_write(0, 32'h0001_0050, d, 16'hFFFF);
        do_idle();
        do_read(0, 32'h0000_0050, 1'b0);
        checks++; if (last_rd !== d) begin errors++; $display("FAIL alias_data got %h want %h", last_rd, d); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int s;
            logic [31:0] a;
            s = int'($urandom_range(0, 1));
            a = {18'h0, 10'($urandom_range(0, 15)), 4'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                do_write(s, a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            end else begin
                do_read(s, a, 1'($urandom));
            end
        end
        do_idle();
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; wr = 1'b0; sel = 0;
        wdata = '0; be = '0; addr = '0;
        for (int i = 0; i < 1024; i++) begin
            sram0[i] = '0; sram3[i] = '0;
            ref_mem[0][i] = '0; ref_mem[1][i] = '0;
        end
        test_reset();
        test_write_read();
        test_partial();
        test_back_to_back();
        test_read_wait();
        test_reset_mid_read();
        test_window();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
